// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine transaction controller.
package vend_pkg;

    localparam int unsigned VAL_W = 4;
    localparam logic [VAL_W-1:0] VAL_MAX = 4'd15;

    localparam logic DISP_SEL_COIN = 1'b0;
    localparam logic DISP_SEL_CNT  = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StCount = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/vend_tick_gen.sv
// Countdown prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module vend_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] pre_q;

    assign tick = en && (pre_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + CW'(1);
        end
    end

endmodule

// File: rtl/vend_disp_ctrl.sv
// Vending transaction controller: coin accumulation, buy/cancel handling,
// post-purchase countdown and display mux select.
module vend_disp_ctrl
    import vend_pkg::*;
#(
    parameter logic [VAL_W-1:0] PRICE     = 4'd5,
    parameter logic [VAL_W-1:0] CNT_START = 4'd9,
    parameter int unsigned      TICK_DIV  = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coin_valid,
    input  logic [VAL_W-1:0] coin_amt,
    input  logic             buy,
    input  logic             cancel,
    output logic             sel_disp,
    output logic [VAL_W-1:0] coin_total,
    output logic [VAL_W-1:0] count_val,
    output logic             dispense,
    output logic             change_valid,
    output logic [VAL_W-1:0] change_amt,
    output logic             coin_reject,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] coin_total_q, coin_total_d;
    logic [VAL_W-1:0] count_val_q, count_val_d;
    logic [VAL_W-1:0] change_amt_q, change_amt_d;
    logic             sel_disp_q, sel_disp_d;
    logic             dispense_q, dispense_d;
    logic             change_valid_q, change_valid_d;
    logic             coin_reject_q, coin_reject_d;
    logic             busy_q, busy_d;
    logic             tick_clr, tick;
    logic [VAL_W:0]   coin_sum;

    vend_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .en   (state_q == StCount),
        .tick (tick)
    );

    // Widened so an overflowing coin is detected rather than wrapped.
    assign coin_sum = {1'b0, coin_total_q} + {1'b0, coin_amt};

    always_comb begin
        state_d        = state_q;
        coin_total_d   = coin_total_q;
        count_val_d    = count_val_q;
        change_amt_d   = change_amt_q;
        sel_disp_d     = sel_disp_q;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        tick_clr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (coin_valid && coin_amt != '0) begin
                    coin_total_d = coin_amt;
                    state_d      = StAccum;
                end
            end
            StAccum: begin
                if (cancel) begin
                    change_amt_d   = coin_total_q;
                    change_valid_d = 1'b1;
                    coin_total_d   = '0;
                    coin_reject_d  = coin_valid;
                    state_d        = StIdle;
                end else if (buy && coin_total_q >= PRICE) begin
                    change_amt_d  = coin_total_q - PRICE;
                    count_val_d   = CNT_START;
                    sel_disp_d    = DISP_SEL_CNT;
                    tick_clr      = 1'b1;
                    coin_reject_d = coin_valid;
                    state_d       = StCount;
                end else if (coin_valid) begin
                    if (coin_sum <= {1'b0, VAL_MAX}) begin
                        coin_total_d = coin_sum[VAL_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            StCount: begin
                coin_reject_d = coin_valid;
                if (tick) begin
                    count_val_d = count_val_q - 4'd1;
                    if (count_val_q == 4'd1) begin
                        dispense_d     = 1'b1;
                        change_valid_d = 1'b1;
                        state_d        = StDone;
                    end
                end
            end
            StDone: begin
                coin_reject_d = coin_valid;
                coin_total_d  = '0;
                count_val_d   = '0;
                sel_disp_d    = DISP_SEL_COIN;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StCount) || (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            coin_total_q   <= '0;
            count_val_q    <= '0;
            change_amt_q   <= '0;
            sel_disp_q     <= DISP_SEL_COIN;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            coin_total_q   <= coin_total_d;
            count_val_q    <= count_val_d;
            change_amt_q   <= change_amt_d;
            sel_disp_q     <= sel_disp_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
        end
    end

    assign sel_disp     = sel_disp_q;
    assign coin_total   = coin_total_q;
    assign count_val    = count_val_q;
    assign change_amt   = change_amt_q;
    assign dispense     = dispense_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = busy_q;

endmodule
